jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that sequences the JTAG data-register block and owns the instruction and shift registers. It decodes TMS into the 16-state TAP state machine and generates the Capture/Shift/Update actions for the DR and IR paths. It presents the selected instruction and the shifted data to `jtag_dataReg`, and returns `jtag_dataReg`'s muxed output on TDO. It sits between the chip-level TCK/TMS/TDI/TDO/TRST pins and `jtag_dataReg`.

## Interface
Parameters (from package `jtag_pa`, not overridable per instance):
- REG_W: from `jtag_pa`; width of the shift, instruction and data registers.
- IDCODE, BYPASS, BSR, USER: from `jtag_pa`; REG_W-bit instruction codes.

Ports:
- i_tclk  input  1  TAP clock (TCK).
- i_trst_n  input  1  reset, asynchronous, active-low.
- i_tms  input  1  test mode select, sampled on posedge i_tclk.
- i_tdi  input  1  test data in, sampled on posedge i_tclk.
- i_dataReg  input  REG_W  selected data register from `jtag_dataReg`; parallel capture source.
- o_tdo  output  1  test data out, driven on negedge i_tclk.
- o_tdoEn  output  1  TDO output enable; high only while shifting.
- o_instrReg  output  REG_W  current instruction; drives `jtag_dataReg` mux select.
- o_shiftReg  output  REG_W  DR shift register contents.
- o_stateIsUpdateDr  output  1  high while the state is UPDATE_DR.
- o_state  output  4  current TAP state, for debug.

## Operation
- FSM states: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR.
- Transitions follow the standard 1149.1 TMS graph.
- Five consecutive TMS=1 edges reach TEST_LOGIC_RESET from any state.
- The FSM advances on every posedge i_tclk. All register actions below are keyed on the state held before that edge.

DR path (shift_q, REG_W bits):
- CAPTURE_DR: shift_q <= i_dataReg. For BYPASS, shift_q <= '0.
- SHIFT_DR, non-BYPASS: shift_q <= {i_tdi, shift_q[REG_W-1:1]}, i.e. LSB first out, TDI into the MSB.
- SHIFT_DR, BYPASS: chain length is 1. shift_q[0] <= i_tdi; the upper bits hold.
- Other states: shift_q holds.

IR path:
- CAPTURE_IR: ir_shift_q <= {(REG_W-2)'(0), 2'b01}.
- SHIFT_IR: ir_shift_q <= {i_tdi, ir_shift_q[REG_W-1:1]}.
- UPDATE_IR: instr_q <= ir_shift_q.
- TEST_LOGIC_RESET: instr_q <= IDCODE on every edge.

Outputs:
- o_stateIsUpdateDr = (state_q == UPDATE_DR). It is a one-cycle pulse per DR scan, so `jtag_dataReg` loads USER on the edge that leaves UPDATE_DR.
- o_tdo:
  - In SHIFT_DR it is shift_q[0].
  - In SHIFT_IR it is ir_shift_q[0].
  - Otherwise it holds its last value.
- o_tdoEn = 1 exactly while the state is SHIFT_DR or SHIFT_IR.
- Undefined instruction codes are passed through unchanged. `jtag_dataReg` returns '0 for them and this block shifts that value, full REG_W length.

## Timing
Reset (async, when i_trst_n=0):
- state_q = TEST_LOGIC_RESET, instr_q = IDCODE.
- shift_q = '0, ir_shift_q = '0.
- o_tdo = 0, o_tdoEn = 0.
- Reset overrides everything, including mid-shift; on release no update occurs.

Edges and latency:
- State, shift and instruction registers use posedge i_tclk. o_tdo and o_tdoEn use negedge i_tclk.
- TDO latency: the first captured bit appears on the negedge after the CAPTURE_DR→SHIFT_DR edge. Each subsequent bit appears half a cycle after each shift edge.
- BYPASS: TDO equals TDI delayed by one TCK.
- A new instruction takes effect (o_instrReg) on the edge leaving UPDATE_IR. The next CAPTURE_DR uses it.

Boundary conditions:
- Any PAUSE state holds both shift registers.
- EXIT1 followed by UPDATE with no shift edges updates the register with the captured value.

## Structure
- Package `jtag_pa` owns REG_W, ID_CODE and the instruction constants.
- Add to `jtag_pa` a `tap_state_t` enum (4-bit, encoding per 1149.1 as listed above) and the IR capture constant.
- Natural sub-module: `jtag_tap_fsm` (TMS → next state, plus one-hot state decode). Shift and IR logic stays in the top.

## Test plan
- Reset escape: put the FSM in SHIFT_DR, then drive TMS=1 for 5 edges → o_state=TEST_LOGIC_RESET, o_instrReg=IDCODE, o_tdoEn=0.
- IDCODE read: from reset apply TMS 0,1,0,0, then REG_W shift edges with TMS=1 on the last → o_tdo serially emits ID_CODE LSB first; o_tdoEn is high for exactly REG_W negedges.
- USER write: load IR=USER, then DR-scan 0x000000A5 → o_stateIsUpdateDr is high for exactly one cycle with o_shiftReg=0x000000A5; the next USER capture reads back 0xA5.
- BYPASS: load IR=BYPASS, shift TDI pattern 1,0,1,1 → o_tdo = 0,1,0,1 (a one-TCK delay, with the captured 0 first).
- IR capture: scan IR with TDI=0 → the first two TDO bits are 1 then 0.
- Async reset mid-scan: assert i_trst_n=0 in SHIFT_DR between clock edges → immediate TEST_LOGIC_RESET, o_tdoEn=0, and no o_stateIsUpdateDr pulse.

Source files
------------

// File: rtl/jtag_pa.sv
// Shared JTAG constants: register width, IDCODE value, instruction codes and TAP state encoding.
package jtag_pa;

    localparam int REG_W = 32;

    localparam logic [REG_W-1:0] ID_CODE = 32'h4BA0_0477;

    localparam logic [REG_W-1:0] IDCODE = 32'h0000_0001;
    localparam logic [REG_W-1:0] BSR    = 32'h0000_0002;
    localparam logic [REG_W-1:0] USER   = 32'h0000_0003;
    localparam logic [REG_W-1:0] BYPASS = {REG_W{1'b1}};

    // Fixed 2'b01 in the low bits lets a host spot IR chain boundaries.
    localparam logic [REG_W-1:0] IR_CAPTURE = {{(REG_W-2){1'b0}}, 2'b01};

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    // Decoded state flags consumed by the register datapath.
    typedef struct packed {
        logic tlr;
        logic cap_dr;
        logic sh_dr;
        logic upd_dr;
        logic cap_ir;
        logic sh_ir;
        logic upd_ir;
    } tap_dec_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine driven by TMS, with decoded action flags.
module jtag_tap_fsm
    import jtag_pa::*;
(
    input  logic       tclk,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state,
    output tap_dec_t   dec
);

    tap_state_t state_q, state_d;

    always_ff @(posedge tclk or negedge trst_n) begin
        if (!trst_n) state_q <= TEST_LOGIC_RESET;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_DR:        state_d = tms ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR  : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.tlr    = (state_q == TEST_LOGIC_RESET);
        dec.cap_dr = (state_q == CAPTURE_DR);
        dec.sh_dr  = (state_q == SHIFT_DR);
        dec.upd_dr = (state_q == UPDATE_DR);
        dec.cap_ir = (state_q == CAPTURE_IR);
        dec.sh_ir  = (state_q == SHIFT_IR);
        dec.upd_ir = (state_q == UPDATE_IR);
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: owns the DR/IR shift registers and instruction register, drives TDO on negedge.
module jtag_tap_ctrl
    import jtag_pa::*;
(
    input  logic             i_tclk,
    input  logic             i_trst_n,
    input  logic             i_tms,
    input  logic             i_tdi,
    input  logic [REG_W-1:0] i_dataReg,
    output logic             o_tdo,
    output logic             o_tdoEn,
    output logic [REG_W-1:0] o_instrReg,
    output logic [REG_W-1:0] o_shiftReg,
    output logic             o_stateIsUpdateDr,
    output logic [3:0]       o_state
);

    tap_state_t       state;
    tap_dec_t         dec;
    logic [REG_W-1:0] shift_q;
    logic [REG_W-1:0] ir_shift_q;
    logic [REG_W-1:0] instr_q;
    logic             tdo_q;
    logic             tdo_en_q;
    logic             is_bypass;

    jtag_tap_fsm u_fsm (
        .tclk   (i_tclk),
        .trst_n (i_trst_n),
        .tms    (i_tms),
        .state  (state),
        .dec    (dec)
    );

    assign is_bypass = (instr_q == BYPASS);

    // BYPASS shortens the chain to one bit: only bit 0 moves, the rest hold.
    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            shift_q <= '0;
        end else if (dec.cap_dr) begin
            shift_q <= is_bypass ? '0 : i_dataReg;
        end else if (dec.sh_dr) begin
            if (is_bypass) shift_q[0] <= i_tdi;
            else           shift_q    <= {i_tdi, shift_q[REG_W-1:1]};
        end
    end

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n)       ir_shift_q <= '0;
        else if (dec.cap_ir) ir_shift_q <= IR_CAPTURE;
        else if (dec.sh_ir)  ir_shift_q <= {i_tdi, ir_shift_q[REG_W-1:1]};
    end

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n)       instr_q <= IDCODE;
        else if (dec.tlr)    instr_q <= IDCODE;
        else if (dec.upd_ir) instr_q <= ir_shift_q;
    end

    // TDO launches on the falling edge so the host samples it cleanly on the next rise.
    always_ff @(negedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= dec.sh_dr | dec.sh_ir;
            if (dec.sh_dr)      tdo_q <= shift_q[0];
            else if (dec.sh_ir) tdo_q <= ir_shift_q[0];
        end
    end

    assign o_tdo             = tdo_q;
    assign o_tdoEn           = tdo_en_q;
    assign o_instrReg        = instr_q;
    assign o_shiftReg        = shift_q;
    assign o_stateIsUpdateDr = dec.upd_dr;
    assign o_state           = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with a small behavioural jtag_dataReg model.
module tb_jtag_tap_ctrl;
    import jtag_pa::*;

    logic             i_tclk = 1'b0;
    logic             i_trst_n;
    logic             i_tms;
    logic             i_tdi;
    logic [REG_W-1:0] i_dataReg;
    logic             o_tdo;
    logic             o_tdoEn;
    logic [REG_W-1:0] o_instrReg;
    logic [REG_W-1:0] o_shiftReg;
    logic             o_stateIsUpdateDr;
    logic [3:0]       o_state;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    int upd_cnt = 0;
    logic [REG_W-1:0] upd_shift;
    logic [REG_W-1:0] user_q;

    jtag_tap_ctrl dut (
        .i_tclk            (i_tclk),
        .i_trst_n          (i_trst_n),
        .i_tms             (i_tms),
        .i_tdi             (i_tdi),
        .i_dataReg         (i_dataReg),
        .o_tdo             (o_tdo),
        .o_tdoEn           (o_tdoEn),
        .o_instrReg        (o_instrReg),
        .o_shiftReg        (o_shiftReg),
        .o_stateIsUpdateDr (o_stateIsUpdateDr),
        .o_state           (o_state)
    );

    always #5 i_tclk = ~i_tclk;

    // Data-register block model: USER loads on the edge leaving UPDATE_DR.
    always @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) user_q <= '0;
        else if (o_stateIsUpdateDr && o_instrReg == USER) user_q <= o_shiftReg;
    end

    always_comb begin
        case (o_instrReg)
            IDCODE:  i_dataReg = ID_CODE;
            USER:    i_dataReg = user_q;
            BSR:     i_dataReg = 32'h0F0F_5A5A;
            BYPASS:  i_dataReg = 32'hFFFF_FFFF;
            default: i_dataReg = '0;
        endcase
    end

    // One TCK: drive, rise, fall, then settle so outputs are sampled mid-low-phase.
    task automatic step(input logic tms, input logic tdi);
        i_tms = tms;
        i_tdi = tdi;
        @(posedge i_tclk);
        @(negedge i_tclk);
        #1;
        if (o_tdoEn) en_cnt++;
        if (o_stateIsUpdateDr) begin
            upd_cnt++;
            upd_shift = o_shiftReg;
        end
    endtask

    task automatic scan_ir(input logic [REG_W-1:0] din, output logic [REG_W-1:0] dout);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        dout[0] = o_tdo;
        for (int i = 0; i < REG_W; i++) begin
            step(i == REG_W - 1, din[i]);
            if (i < REG_W - 1) dout[i+1] = o_tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic scan_dr(input logic [REG_W-1:0] din, output logic [REG_W-1:0] dout);
        step(1, 0); step(0, 0); step(0, 0);
        dout[0] = o_tdo;
        for (int i = 0; i < REG_W; i++) begin
            step(i == REG_W - 1, din[i]);
            if (i < REG_W - 1) dout[i+1] = o_tdo;
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic test_reset();
        i_trst_n = 0; i_tms = 1; i_tdi = 0;
        #12;
        tests++; if (o_state !== 4'(TEST_LOGIC_RESET)) begin fails++; $display("FAIL reset_state: got %0d want %0d", o_state, TEST_LOGIC_RESET); end
        tests++; if (o_instrReg !== IDCODE) begin fails++; $display("FAIL reset_instr: got %h want %h", o_instrReg, IDCODE); end
        tests++; if (o_shiftReg !== '0) begin fails++; $display("FAIL reset_shift: got %h want 0", o_shiftReg); end
        tests++; if (o_tdo !== 1'b0 || o_tdoEn !== 1'b0) begin fails++; $display("FAIL reset_tdo: got tdo=%b en=%b want 0 0", o_tdo, o_tdoEn); end
        i_trst_n = 1;
        @(negedge i_tclk); #1;
        tests++; if (o_state !== 4'(TEST_LOGIC_RESET)) begin fails++; $display("FAIL reset_release_state: got %0d want %0d", o_state, TEST_LOGIC_RESET); end
        step(0, 0);
        tests++; if (o_state !== 4'(RUN_TEST_IDLE)) begin fails++; $display("FAIL to_idle: got %0d want %0d", o_state, RUN_TEST_IDLE); end
    endtask

    task automatic test_idcode();
        logic [REG_W-1:0] d;
        en_cnt = 0; upd_cnt = 0;
        scan_dr('0, d);
        tests++; if (d !== ID_CODE) begin fails++; $display("FAIL idcode_read: got %h want %h", d, ID_CODE); end
        tests++; if (en_cnt != REG_W) begin fails++; $display("FAIL idcode_tdoen_len: got %0d want %0d", en_cnt, REG_W); end
        tests++; if (upd_cnt != 1) begin fails++; $display("FAIL idcode_upd_pulse: got %0d want 1", upd_cnt); end
    endtask

    task automatic test_user_write();
        logic [REG_W-1:0] d;
        scan_ir(USER, d);
        tests++; if (d !== IR_CAPTURE) begin fails++; $display("FAIL ir_capture_user: got %h want %h", d, IR_CAPTURE); end
        tests++; if (o_instrReg !== USER) begin fails++; $display("FAIL ir_load_user: got %h want %h", o_instrReg, USER); end
        upd_cnt = 0;
        scan_dr(32'h0000_00A5, d);
        tests++; if (upd_cnt != 1) begin fails++; $display("FAIL user_upd_pulse: got %0d want 1", upd_cnt); end
        tests++; if (upd_shift !== 32'h0000_00A5) begin fails++; $display("FAIL user_upd_shift: got %h want 000000a5", upd_shift); end
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL user_first_capture: got %h want 0", d); end
        scan_dr(32'h0, d);
        tests++; if (d !== 32'h0000_00A5) begin fails++; $display("FAIL user_readback: got %h want 000000a5", d); end
    endtask

    task automatic test_pause();
        logic [REG_W-1:0] d;
        scan_dr(32'h1234_5678, d);
        step(1, 0); step(0, 0); step(1, 0); step(1, 0);
        tests++; if (!o_stateIsUpdateDr || o_shiftReg !== 32'h1234_5678) begin fails++; $display("FAIL exit1_update: got upd=%b shift=%h want 1 12345678", o_stateIsUpdateDr, o_shiftReg); end
        step(0, 0);
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(1, 0);
        step(0, 1); step(0, 1); step(0, 1);
        tests++; if (o_state !== 4'(PAUSE_DR) || o_shiftReg !== 32'h448D_159E || o_tdoEn !== 1'b0) begin fails++; $display("FAIL pause_hold: got st=%0d shift=%h en=%b want %0d 448d159e 0", o_state, o_shiftReg, o_tdoEn, PAUSE_DR); end
        step(1, 0); step(1, 0);
        tests++; if (o_shiftReg !== 32'h448D_159E) begin fails++; $display("FAIL pause_update: got %h want 448d159e", o_shiftReg); end
        step(0, 0);
    endtask

    task automatic test_bypass();
        logic [REG_W-1:0] d;
        logic [3:0] obs;
        scan_ir(BYPASS, d);
        tests++; if (o_instrReg !== BYPASS) begin fails++; $display("FAIL ir_load_bypass: got %h want %h", o_instrReg, BYPASS); end
        upd_cnt = 0;
        step(1, 0); step(0, 0); step(0, 0);
        obs[0] = o_tdo;
        step(0, 1); obs[1] = o_tdo;
        step(0, 0); obs[2] = o_tdo;
        step(0, 1); obs[3] = o_tdo;
        step(1, 1);
        step(1, 0);
        tests++; if (obs !== 4'b1010) begin fails++; $display("FAIL bypass_tdo: got %b want 1010 (bit0 first)", obs); end
        tests++; if (upd_cnt != 1 || upd_shift !== 32'h0000_0001) begin fails++; $display("FAIL bypass_chain_len: got cnt=%0d shift=%h want 1 00000001", upd_cnt, upd_shift); end
        step(0, 0);
    endtask

    task automatic test_ir_capture();
        logic [REG_W-1:0] d;
        scan_ir('0, d);
        tests++; if (d[1:0] !== 2'b01) begin fails++; $display("FAIL ir_capture_bits: got %b want 01 (1 first)", d[1:0]); end
        tests++; if (o_instrReg !== '0) begin fails++; $display("FAIL ir_undefined_load: got %h want 0", o_instrReg); end
        scan_dr(32'hFFFF_FFFF, d);
        tests++; if (d !== '0 || upd_shift !== 32'hFFFF_FFFF) begin fails++; $display("FAIL undefined_dr: got cap=%h shift=%h want 0 ffffffff", d, upd_shift); end
    endtask

    task automatic test_reset_escape();
        step(1, 0); step(0, 0); step(0, 0);
        tests++; if (o_tdoEn !== 1'b1) begin fails++; $display("FAIL escape_in_shift: got en=%b want 1", o_tdoEn); end
        for (int i = 0; i < 5; i++) step(1, 0);
        tests++; if (o_state !== 4'(TEST_LOGIC_RESET) || o_tdoEn !== 1'b0) begin fails++; $display("FAIL escape_tlr: got st=%0d en=%b want %0d 0", o_state, o_tdoEn, TEST_LOGIC_RESET); end
        step(1, 0);
        tests++; if (o_instrReg !== IDCODE) begin fails++; $display("FAIL escape_instr: got %h want %h", o_instrReg, IDCODE); end
        step(0, 0);
    endtask

    task automatic test_async_reset();
        logic [REG_W-1:0] d;
        scan_ir(USER, d);
        step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 1);
        upd_cnt = 0;
        i_trst_n = 0;
        #1;
        tests++; if (o_state !== 4'(TEST_LOGIC_RESET) || o_tdoEn !== 1'b0 || o_stateIsUpdateDr !== 1'b0) begin fails++; $display("FAIL async_reset_now: got st=%0d en=%b upd=%b want %0d 0 0", o_state, o_tdoEn, o_stateIsUpdateDr, TEST_LOGIC_RESET); end
        tests++; if (o_instrReg !== IDCODE || o_shiftReg !== '0) begin fails++; $display("FAIL async_reset_regs: got ir=%h shift=%h want %h 0", o_instrReg, o_shiftReg, IDCODE); end
        #1 i_trst_n = 1;
        step(1, 0); step(1, 0); step(0, 0);
        tests++; if (upd_cnt != 0 || o_state !== 4'(RUN_TEST_IDLE)) begin fails++; $display("FAIL async_reset_release: got upd=%0d st=%0d want 0 %0d", upd_cnt, o_state, RUN_TEST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_user_write();
        test_pause();
        test_bypass();
        test_ir_capture();
        test_reset_escape();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
